// File: rtl/dkong_input_ctrl.sv
// Player-input conditioning for the Donkey Kong core: PS/2 + joystick merge, rotate remap
// and a timed coin/gap/start credit sequencer. Keyboard decode is enabled by DKIN_KEYBOARD_EN.
//
// state     | meaning
// S_IDLE    | waiting for a start rising edge
// S_COIN    | O_C1 low for COIN_CYC clocks
// S_GAP     | all credit outputs high for GAP_CYC clocks
// S_START   | O_S1 or O_S2 low for START_CYC clocks
// S_RELEASE | waiting for both start requests to drop
module dkong_input_ctrl #(
  parameter int COIN_CYC  = 2457600,
  parameter int GAP_CYC   = 1228800,
  parameter int START_CYC = 2457600
) (
  input  logic        I_CLK_24576M,
  input  logic        I_RESETn,
  input  logic [10:0] I_PS2_KEY,
  input  logic [15:0] I_JOY,
  input  logic        I_ROTATE,
  output logic        O_U,
  output logic        O_D,
  output logic        O_L,
  output logic        O_R,
  output logic        O_J,
  output logic        O_S1,
  output logic        O_S2,
  output logic        O_C1,
  output logic        O_BUSY
);

  localparam logic [23:0] COIN_LD  = 24'(COIN_CYC - 1);
  localparam logic [23:0] GAP_LD   = 24'(GAP_CYC - 1);
  localparam logic [23:0] START_LD = 24'(START_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COIN    = 3'd1,
    S_GAP     = 3'd2,
    S_START   = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  // key latch vector: {s2, s1, fire, right, left, down, up}
  logic [6:0] key;

`ifdef DKIN_KEYBOARD_EN
  logic       tog_q;
  logic [6:0] key_q, key_d;
  logic       key_ev;
  logic       pressed;
  logic [8:0] code;

  assign key_ev  = I_PS2_KEY[10] ^ tog_q;
  assign pressed = I_PS2_KEY[9];
  assign code    = I_PS2_KEY[8:0];

  // Direction keys match on the scancode alone; the others need extended = 0.
  always_comb begin
    key_d = key_q;
    if (key_ev) begin
      if (code[7:0] == 8'h75)                      key_d[0] = pressed;
      else if (code[7:0] == 8'h72)                 key_d[1] = pressed;
      else if (code[7:0] == 8'h6B)                 key_d[2] = pressed;
      else if (code[7:0] == 8'h74)                 key_d[3] = pressed;
      else if (code == 9'h029 || code == 9'h014)   key_d[4] = pressed;
      else if (code == 9'h005)                     key_d[5] = pressed;
      else if (code == 9'h006)                     key_d[6] = pressed;
    end
  end

  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      tog_q <= 1'b0;
      key_q <= '0;
    end else begin
      tog_q <= I_PS2_KEY[10];
      key_q <= key_d;
    end
  end

  assign key = key_q;
`else
  logic unused_ps2;
  assign unused_ps2 = ^I_PS2_KEY;
  assign key = '0;
`endif

  logic unused_joy;
  assign unused_joy = ^I_JOY[15:7];

  logic req_u, req_d, req_l, req_r, req_f, st1_raw, st2_raw;
  logic up_n, dn_n, lf_n, rt_n;

  assign up_n    = key[0] | I_JOY[3];
  assign dn_n    = key[1] | I_JOY[2];
  assign lf_n    = key[2] | I_JOY[1];
  assign rt_n    = key[3] | I_JOY[0];
  assign req_f   = key[4] | I_JOY[4];
  assign st1_raw = key[5] | I_JOY[5];
  assign st2_raw = key[6] | I_JOY[6];

  assign req_u = I_ROTATE ? lf_n : up_n;
  assign req_d = I_ROTATE ? rt_n : dn_n;
  assign req_l = I_ROTATE ? dn_n : lf_n;
  assign req_r = I_ROTATE ? up_n : rt_n;

  logic [4:0] dir_q;
  logic       st1_q, st2_q, st1_prev_q, st2_prev_q;
  logic       rise1, rise2;

  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      dir_q      <= 5'b11111;
      st1_q      <= 1'b0;
      st2_q      <= 1'b0;
      st1_prev_q <= 1'b0;
      st2_prev_q <= 1'b0;
    end else begin
      dir_q      <= ~{req_u, req_d, req_l, req_r, req_f};
      st1_q      <= st1_raw;
      st2_q      <= st2_raw;
      st1_prev_q <= st1_q;
      st2_prev_q <= st2_q;
    end
  end

  assign rise1 = st1_q & ~st1_prev_q;
  assign rise2 = st2_q & ~st2_prev_q;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        sel_q, sel_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (rise1 || rise2) begin
          sel_d   = rise1;
          cnt_d   = COIN_LD;
          state_d = S_COIN;
        end
      end
      S_COIN: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_LD;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          cnt_d   = START_LD;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      S_START: begin
        if (cnt_q == '0) state_d = S_RELEASE;
        else             cnt_d   = cnt_q - 24'd1;
      end
      S_RELEASE: begin
        if (!st1_q && !st2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic c1_q, s1_q, s2_q, busy_q;

  // Credit outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      c1_q    <= 1'b1;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      c1_q    <= ~(state_d == S_COIN);
      s1_q    <= ~((state_d == S_START) && sel_d);
      s2_q    <= ~((state_d == S_START) && !sel_d);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign {O_U, O_D, O_L, O_R, O_J} = dir_q;
  assign O_S1   = s1_q;
  assign O_S2   = s2_q;
  assign O_C1   = c1_q;
  assign O_BUSY = busy_q;

endmodule

// File: tb/tb_dkong_input_ctrl.sv
// Self-checking bench for dkong_input_ctrl (COIN_CYC=4, GAP_CYC=2, START_CYC=3).
module tb_dkong_input_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] ps2_key = '0;
  logic [15:0] joy = 16'hFFFF;
  logic        rot = 1'b0;
  logic        o_u, o_d, o_l, o_r, o_j, o_s1, o_s2, o_c1, o_busy;

  dkong_input_ctrl #(.COIN_CYC(4), .GAP_CYC(2), .START_CYC(3)) dut (
    .I_CLK_24576M(clk), .I_RESETn(rst_n), .I_PS2_KEY(ps2_key), .I_JOY(joy),
    .I_ROTATE(rot), .O_U(o_u), .O_D(o_d), .O_L(o_l), .O_R(o_r), .O_J(o_j),
    .O_S1(o_s1), .O_S2(o_s2), .O_C1(o_c1), .O_BUSY(o_busy)
  );

  always #5 clk = ~clk;

  // {busy, U, D, L, R, J, S1, S2, C1}
  wire [8:0] outs = {o_busy, o_u, o_d, o_l, o_r, o_j, o_s1, o_s2, o_c1};

  int checks = 0;
  int passes = 0;
  logic ps2_tog = 1'b0;

  typedef struct {
    logic [15:0] joy;
    logic        rot;
    logic [8:0]  exp;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [8:0] want);
    checks++;
    if (outs === want) passes++;
    else $display("FAIL %s got %h want %h", name, outs, want);
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s got %0d want %0d", name, got, want);
  endtask

  task automatic ps2(input logic pressed, input logic [8:0] code);
    ps2_tog = ~ps2_tog;
    ps2_key = {ps2_tog, pressed, code};
  endtask

  function automatic int key_idx(input logic [8:0] c);
    if (c[7:0] == 8'h75) return 0;
    if (c[7:0] == 8'h72) return 1;
    if (c[7:0] == 8'h6B) return 2;
    if (c[7:0] == 8'h74) return 3;
    if (c == 9'h029 || c == 9'h014) return 4;
    return -1;
  endfunction

  vec_t vecs[18];
  logic [8:0] kb_u_low;
  int c1_low, s1_low, s2_low, busy_hi;

  initial begin
`ifdef DKIN_KEYBOARD_EN
    kb_u_low = 9'h07F;
`else
    kb_u_low = 9'h0FF;
`endif
    vecs[0]  = '{16'h0008, 1'b0, 9'h07F};
    vecs[1]  = '{16'h0008, 1'b1, 9'h0EF};
    vecs[2]  = '{16'h0002, 1'b1, 9'h07F};
    vecs[3]  = '{16'h0001, 1'b1, 9'h0BF};
    vecs[4]  = '{16'h0004, 1'b1, 9'h0DF};
    vecs[5]  = '{16'hFF90, 1'b0, 9'h0F7};
    vecs[6]  = '{16'h0040, 1'b0, 9'h0FF};
    vecs[7]  = '{16'h0000, 1'b0, 9'h1FE};
    vecs[8]  = '{16'h0000, 1'b0, 9'h1FE};
    vecs[9]  = '{16'h0000, 1'b0, 9'h1FE};
    vecs[10] = '{16'h0000, 1'b0, 9'h1FE};
    vecs[11] = '{16'h0000, 1'b0, 9'h1FF};
    vecs[12] = '{16'h0000, 1'b0, 9'h1FF};
    vecs[13] = '{16'h0000, 1'b0, 9'h1FD};
    vecs[14] = '{16'h0000, 1'b0, 9'h1FD};
    vecs[15] = '{16'h0000, 1'b0, 9'h1FD};
    vecs[16] = '{16'h0000, 1'b0, 9'h1FF};
    vecs[17] = '{16'h0000, 1'b0, 9'h0FF};

    // reset
    #23;
    chk("reset_hold", 9'h0FF);
    joy = 16'h0000;
    #2 rst_n = 1'b1;
    step();
    chk("reset_release", 9'h0FF);
    step();
    chk("reset_idle", 9'h0FF);

    // joystick / rotate / basic credit sequence
    for (int i = 0; i < 18; i++) begin
      joy = vecs[i].joy;
      rot = vecs[i].rot;
      step();
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // PS/2 decode
    rot = 1'b0;
    joy = '0;
    ps2(1'b1, 9'h075);
    step();
    chk("ps2_up_latch", 9'h0FF);
    step();
    chk("ps2_up_press", kb_u_low);
    ps2(1'b0, 9'h175);
    step();
    chk("ps2_up_hold", kb_u_low);
    step();
    chk("ps2_up_release", 9'h0FF);
    ps2(1'b1, 9'h01C);
    step();
    step();
    chk("ps2_unknown", 9'h0FF);

    // priority and discard during GAP
    joy = 16'h0060;
    step();
    joy = 16'h0000;
    step();
    chk("prio_coin", 9'h1FE);
    repeat (4) step();
    chk("prio_gap", 9'h1FF);
    joy = 16'h0040;
    step();
    chk("prio_gap_edge", 9'h1FF);
    joy = 16'h0000;
    step();
    chk("prio_s1", 9'h1FB);
    step();
    step();
    chk("prio_s1_end", 9'h1FB);
    step();
    chk("prio_release", 9'h1FF);
    step();
    chk("prio_idle", 9'h0FF);
    c1_low = 0;
    repeat (12) begin
      step();
      if (!o_c1) c1_low++;
    end
    chk_int("discard_no_coin", c1_low, 0);

    // hold start1 for 20 clocks
    joy = 16'h0020;
    c1_low = 0; s1_low = 0; s2_low = 0;
    repeat (20) begin
      step();
      if (!o_c1) c1_low++;
      if (!o_s1) s1_low++;
      if (!o_s2) s2_low++;
      if (!o_c1 && (!o_s1 || !o_s2)) c1_low += 100;
    end
    chk_int("hold_coin_cnt", c1_low, 4);
    chk_int("hold_s1_cnt", s1_low, 3);
    chk_int("hold_s2_cnt", s2_low, 0);
    chk("hold_busy", 9'h1FF);
    joy = 16'h0000;
    step();
    chk("hold_release1", 9'h1FF);
    step();
    chk("hold_release2", 9'h0FF);
    c1_low = 0;
    repeat (10) begin
      step();
      if (!o_c1) c1_low++;
    end
    chk_int("hold_no_retrigger", c1_low, 0);

    // reset abort during COIN
    joy = 16'h0020;
    step();
    joy = 16'h0000;
    step();
    chk("abort_coin", 9'h1FE);
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_immediate", 9'h0FF);
    #2 rst_n = 1'b1;
    c1_low = 0; busy_hi = 0;
    repeat (12) begin
      step();
      if (!o_c1 || !o_s1 || !o_s2) c1_low++;
      if (o_busy) busy_hi++;
    end
    chk_int("abort_no_pulse", c1_low, 0);
    chk_int("abort_no_busy", busy_hi, 0);

    // randomized directions/fire against a key-state model
    begin
      logic [8:0] pool[12];
      logic       m[5];
      logic       tog_m;
      logic       u, d, l, r, f;
      logic [8:0] exp;
      pool = '{9'h075, 9'h175, 9'h072, 9'h172, 9'h06B, 9'h074,
               9'h029, 9'h014, 9'h01C, 9'h114, 9'h129, 9'h000};
      for (int k = 0; k < 5; k++) m[k] = 1'b0;
      tog_m = ps2_key[10];
      for (int n = 0; n < 300; n++) begin
        joy = 16'($urandom) & 16'hFF9F;
        rot = 1'($urandom);
        if ($urandom_range(2) == 0) ps2(1'($urandom), pool[$urandom_range(11)]);
        if (rot) begin
          u = m[2] | joy[1];
          d = m[3] | joy[0];
          l = m[1] | joy[2];
          r = m[0] | joy[3];
        end else begin
          u = m[0] | joy[3];
          d = m[1] | joy[2];
          l = m[2] | joy[1];
          r = m[3] | joy[0];
        end
        f = m[4] | joy[4];
        exp = {1'b0, ~u, ~d, ~l, ~r, ~f, 3'b111};
        step();
        chk($sformatf("rand%0d", n), exp);
`ifdef DKIN_KEYBOARD_EN
        if (ps2_key[10] != tog_m && key_idx(ps2_key[8:0]) >= 0)
          m[key_idx(ps2_key[8:0])] = ps2_key[9];
`endif
        tog_m = ps2_key[10];
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
